// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad column scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    // Scanner phases: wait for rows to settle, sample once, hold until release.
    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SAMPLE = 2'd1,
        HELD   = 2'd2
    } scan_state_t;

    // Width of a key code covering every matrix position.
    function automatic int key_w_f(input int n_rows, input int n_cols);
        return (n_rows * n_cols > 1) ? $clog2(n_rows * n_cols) : 1;
    endfunction

    // Width of the counter shared by the settle and release phases.
    function automatic int cnt_w_f(input int settle_cyc, input int rel_cyc);
        int m;
        m = (settle_cyc > rel_cyc) ? settle_cyc : rel_cyc;
        return $clog2(m + 1);
    endfunction

    localparam int DFLT_KEY_W = 4;

    // Calculator legend, code = row*4 + col:
    //   row0: 1 2 3 +   row1: 4 5 6 -   row2: 7 8 9 *   row3: C 0 = /
    localparam logic [DFLT_KEY_W-1:0] KEY_1   = 4'd0;
    localparam logic [DFLT_KEY_W-1:0] KEY_2   = 4'd1;
    localparam logic [DFLT_KEY_W-1:0] KEY_3   = 4'd2;
    localparam logic [DFLT_KEY_W-1:0] KEY_ADD = 4'd3;
    localparam logic [DFLT_KEY_W-1:0] KEY_4   = 4'd4;
    localparam logic [DFLT_KEY_W-1:0] KEY_5   = 4'd5;
    localparam logic [DFLT_KEY_W-1:0] KEY_6   = 4'd6;
    localparam logic [DFLT_KEY_W-1:0] KEY_SUB = 4'd7;
    localparam logic [DFLT_KEY_W-1:0] KEY_7   = 4'd8;
    localparam logic [DFLT_KEY_W-1:0] KEY_8   = 4'd9;
    localparam logic [DFLT_KEY_W-1:0] KEY_9   = 4'd10;
    localparam logic [DFLT_KEY_W-1:0] KEY_MUL = 4'd11;
    localparam logic [DFLT_KEY_W-1:0] KEY_CLR = 4'd12;
    localparam logic [DFLT_KEY_W-1:0] KEY_0   = 4'd13;
    localparam logic [DFLT_KEY_W-1:0] KEY_EQ  = 4'd14;
    localparam logic [DFLT_KEY_W-1:0] KEY_DIV = 4'd15;

endpackage

// File: rtl/keypad_key_slot.sv
// One-entry key output register with valid/ready handshake and sticky overflow.
// Latency: event on an edge appears on key_code/key_valid right after that edge.
// Backpressure: while full and not accepted, new events are dropped and ovf is set.
module keypad_key_slot
    import keypad_pkg::*;
#(
    parameter int KEY_W = DFLT_KEY_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_vld,
    input  logic [KEY_W-1:0] evt_code,
    input  logic             key_ready,
    input  logic             ovf_clr,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             ovf
);

    logic accept;
    logic load;
    logic drop;

    // A slot freed by this edge's handshake may take the new event on the same edge.
    assign accept = key_valid && key_ready;
    assign load   = evt_vld && (!key_valid || key_ready);
    assign drop   = evt_vld && key_valid && !key_ready;

    // Slot contents: load a new code, otherwise retire on handshake; hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
        end else if (load) begin
            key_code  <= evt_code;
            key_valid <= 1'b1;
        end else if (accept) begin
            key_valid <= 1'b0;
        end
    end

    // Sticky overflow; a new drop outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning controller for a key matrix fed by debounced row lines.
// Latency: key code valid one edge after the sample cycle; 9 cycles per column idle.
// Backpressure: one-entry slot; events arriving while it is full are dropped (ovf).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int  N_ROWS      = 4,
    parameter int  N_COLS      = 4,
    parameter int  SETTLE_CYC  = 8,
    parameter int  RELEASE_CYC = 4,
    localparam int KEY_W       = key_w_f(N_ROWS, N_COLS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_ROWS-1:0] row_i,
    output logic [N_COLS-1:0] col_o,
    output logic [KEY_W-1:0]  key_code,
    output logic              key_valid,
    input  logic              key_ready,
    input  logic              ovf_clr,
    output logic              ovf
);

    localparam int CNT_W  = cnt_w_f(SETTLE_CYC, RELEASE_CYC);
    localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int NSET_W = $clog2(N_ROWS + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  REL_LAST    = CNT_W'(RELEASE_CYC - 1);
    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(N_COLS - 1);
    localparam logic [N_COLS-1:0] COL_FIRST   = N_COLS'(1);

    scan_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [COL_W-1:0]  col_idx;
    logic [ROW_W-1:0]  row_idx;
    logic [NSET_W-1:0] n_set;
    logic              evt_vld;
    logic [KEY_W-1:0]  evt_code;

    // Count active rows and locate the (last) active one; only used when exactly one is set.
    always_comb begin
        n_set   = '0;
        row_idx = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (row_i[r]) begin
                n_set   = n_set + NSET_W'(1);
                row_idx = ROW_W'(r);
            end
        end
    end

    assign evt_vld  = (state == SAMPLE) && (n_set == NSET_W'(1));
    assign evt_code = KEY_W'(row_idx) * KEY_W'(N_COLS) + KEY_W'(col_idx);

    // Scan FSM: settle on a column, sample once, hold the column until the rows stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SETTLE;
            cnt     <= SETTLE_LOAD;
            col_idx <= '0;
            col_o   <= COL_FIRST;
        end else begin
            unique case (state)
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (n_set == '0) begin
                        col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
                        col_o   <= {col_o[N_COLS-2:0], col_o[N_COLS-1]};
                        cnt     <= SETTLE_LOAD;
                        state   <= SETTLE;
                    end else begin
                        // One key or a ghost/multi-press: either way wait for release.
                        cnt   <= '0;
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (row_i != '0) begin
                        cnt <= '0;
                    end else if (cnt == REL_LAST) begin
                        col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
                        col_o   <= {col_o[N_COLS-2:0], col_o[N_COLS-1]};
                        cnt     <= SETTLE_LOAD;
                        state   <= SETTLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= SETTLE_LOAD;
                end
            endcase
        end
    end

    keypad_key_slot #(
        .KEY_W (KEY_W)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_vld   (evt_vld),
        .evt_code  (evt_code),
        .key_ready (key_ready),
        .ovf_clr   (ovf_clr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: scripted scenarios plus random row activity.
// Latency: n/a.
// Backpressure: key_ready driven randomly and in scripted stalls.
module tb_keypad_scanner;

    localparam int NC     = 4;
    localparam int SETTLE = 8;
    localparam int REL    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] row_i = 4'd0;
    logic [3:0] col_o;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Reference model: current column, settle cycles still to wait, held flag,
    // run of quiet cycles while held, slot occupancy and overflow flag.
    int m_col, m_wait, m_zero;
    bit m_held, m_valid, m_ovf;
    int n_col, n_wait, n_zero;
    bit n_held, n_valid, n_ovf;
    int exp_q[$];

    keypad_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_i     (row_i),
        .col_o     (col_o),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .ovf_clr   (ovf_clr),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_wait = SETTLE; m_zero = 0; m_held = 0; m_valid = 0; m_ovf = 0;
        n_col = 0; n_wait = SETTLE; n_zero = 0; n_held = 0; n_valid = 0; n_ovf = 0;
        exp_q.delete();
    endtask

    task automatic commit();
        m_col = n_col; m_wait = n_wait; m_zero = n_zero;
        m_held = n_held; m_valid = n_valid; m_ovf = n_ovf;
    endtask

    // Predict what the next edge does given the inputs now applied.
    task automatic model_next();
        bit evt;
        int code;
        int ones;
        evt = 0; code = 0;
        ones = $countones(row_i);
        n_col = m_col; n_wait = m_wait; n_zero = m_zero; n_held = m_held;
        if (m_held) begin
            if (ones == 0) begin
                n_zero = m_zero + 1;
                if (n_zero == REL) begin
                    n_held = 0; n_zero = 0; n_wait = SETTLE;
                    n_col = (m_col + 1) % NC;
                end
            end else begin
                n_zero = 0;
            end
        end else if (m_wait > 0) begin
            n_wait = m_wait - 1;
        end else if (ones == 0) begin
            n_col = (m_col + 1) % NC;
            n_wait = SETTLE;
        end else begin
            n_held = 1; n_zero = 0;
            if (ones == 1) begin
                evt = 1;
                for (int r = 0; r < 4; r++) if (row_i[r]) code = r * NC + m_col;
            end
        end
        n_valid = m_valid;
        n_ovf = m_ovf;
        if (evt && (!m_valid || key_ready)) begin
            n_valid = 1;
            exp_q.push_back(code);
        end else if (m_valid && key_ready) begin
            n_valid = 0;
        end
        if (evt && m_valid && !key_ready) n_ovf = 1;
        else if (ovf_clr) n_ovf = 0;
    endtask

    task automatic step(input logic [3:0] r, input logic rdy, input logic clr);
        @(posedge clk);
        commit();
        #1;
        row_i = r; key_ready = rdy; ovf_clr = clr;
        model_next();
    endtask

    task automatic do_reset();
        @(posedge clk);
        commit();
        #1;
        rst_n = 1'b0;
        row_i = 4'd0; key_ready = 1'b1; ovf_clr = 1'b0;
        model_reset();
        mon_en = 1'b1;
        #1;
        chk("rst_col", int'(col_o), 1);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_code", int'(key_code), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_next();
    endtask

    // Monitor: compare visible state every cycle and retire codes on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("col", int'(col_o), 1 << m_col);
            chk("valid", int'(key_valid), int'(m_valid));
            chk("ovf", int'(ovf), int'(m_ovf));
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    chk("code_pending", 0, 1);
                end else begin
                    chk("code", int'(key_code), exp_q[0]);
                    if (key_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] pat;
        int sel, dur;
        model_reset();

        // Idle scan: each column held 9 cycles, no keys.
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            step(4'd0, 1'b1, 1'b0);
            chk("t1_col", int'(col_o), 1 << ((e / 9) % 4));
        end

        // Single key row2/col1 -> code 9, one-cycle pulse, column held until release.
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            step((e >= 10 && e <= 25) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
            if (e == 18) begin
                chk("t2_valid", int'(key_valid), 1);
                chk("t2_code", int'(key_code), 9);
            end
            if (e == 19) chk("t2_pulse", int'(key_valid), 0);
            if (e == 29) chk("t2_hold", int'(col_o), 2);
            if (e == 30) chk("t2_move", int'(col_o), 4);
        end

        // Backpressure overflow: code 0 held, code 15 dropped, then ovf_clr.
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            step((e <= 12) ? 4'b0001 : ((e >= 38 && e <= 48) ? 4'b1000 : 4'b0000),
                 1'b0, (e == 55));
            if (e == 9) begin
                chk("t3_valid0", int'(key_valid), 1);
                chk("t3_code0", int'(key_code), 0);
                chk("t3_ovf0", int'(ovf), 0);
            end
            if (e == 44) begin
                chk("t3_ovf", int'(ovf), 1);
                chk("t3_keep", int'(key_code), 0);
                chk("t3_validk", int'(key_valid), 1);
            end
            if (e == 55) chk("t3_ovf_sticky", int'(ovf), 1);
            if (e == 56) begin
                chk("t3_clr", int'(ovf), 0);
                chk("t3_code_after", int'(key_code), 0);
            end
        end

        // Same-edge accept of code 3 and load of code 5.
        do_reset();
        for (int e = 1; e <= 70; e++) begin
            step((e >= 30 && e <= 37) ? 4'b0001 : ((e >= 55 && e <= 62) ? 4'b0010 : 4'b0000),
                 (e == 59) || (e >= 65), 1'b0);
            if (e == 36) chk("t4_code3", int'(key_code), 3);
            if (e == 60) begin
                chk("t4_valid", int'(key_valid), 1);
                chk("t4_code5", int'(key_code), 5);
                chk("t4_ovf", int'(ovf), 0);
            end
            if (e == 61) chk("t4_hold5", int'(key_code), 5);
        end

        // Ghost / multi-press: no event, held until release.
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            step((e <= 15) ? 4'b0011 : 4'b0000, 1'b1, 1'b0);
            if (e == 10) chk("t5_noevt", int'(key_valid), 0);
            if (e == 19) chk("t5_hold", int'(col_o), 1);
            if (e == 20) chk("t5_move", int'(col_o), 2);
        end

        // Reset while held with a pending key.
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            step(4'b0001, 1'b0, 1'b0);
            if (e == 12) chk("t6_pending", int'(key_valid), 1);
        end
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            step(4'd0, 1'b1, 1'b0);
            if (e == 8) chk("t6_col0", int'(col_o), 1);
            if (e == 9) chk("t6_col1", int'(col_o), 2);
        end

        // Random row activity, backpressure, clears and occasional resets.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            sel = $urandom_range(0, 9);
            if (sel < 5) pat = 4'd0;
            else if (sel < 8) pat = 4'(1 << $urandom_range(0, 3));
            else pat = 4'($urandom_range(1, 15));
            dur = $urandom_range(1, 30);
            for (int k = 0; k < dur; k++)
                step(pat, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        // Drain and make sure every predicted code was delivered.
        for (int k = 0; k < 60; k++) step(4'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Column-scanning controller for a 4x4 key matrix; it is the stage directly downstream of the row debouncer.
- Drives one column at a time and waits for the debounced row lines to settle.
- Samples the rows and encodes a single pressed key into a code, emitted over a valid/ready handshake.
- Holds the active column until the key is released, then resumes scanning.
- Feeds the calculator input logic.

Parameters:
N_ROWS, 4, number of matrix rows; equals the debouncer WIDTH.
N_COLS, 4, number of matrix columns.
SETTLE_CYC, 8, cycles to wait after a column change before sampling; must be >= debouncer sync depth (2) + THRESH + 1.
RELEASE_CYC, 4, consecutive all-zero row samples required to declare a release.

Ports:
clk  input  1  system clock; sole clock domain.
rst_n  input  1  asynchronous, active-low reset.
row_i  input  N_ROWS  debounced row levels, active-high (bit r=1: key in row r of the driven column is pressed).
col_o  output  N_COLS  one-hot active-high column drive.
key_code  output  KEY_W  encoded key, row*N_COLS+col; KEY_W = $clog2(N_ROWS*N_COLS).
key_valid  output  1  key_code holds an unconsumed key.
key_ready  input  1  consumer accepts key_code when key_valid && key_ready.
ovf_clr  input  1  synchronous clear of ovf.
ovf  output  1  sticky: a key was dropped because the slot was full.

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - col_o=0001, col_idx=0, state=SETTLE, counter=SETTLE_CYC-1.
  - key_valid=0, key_code=0, ovf=0.
- SETTLE:
  - counter decrements each cycle; at 0 go to SAMPLE.
  - col_o is constant throughout.
- SAMPLE (one cycle):
  - row_i==0: col_idx advances (N_COLS-1 wraps to 0), col_o updates the same edge, reload counter, go to SETTLE.
  - Exactly one row bit set: emit event {row_idx,col_idx}, go to HELD with release counter=0.
  - More than one row bit set (ghost or multi-press): no event, go to HELD.
- HELD:
  - col_o is held.
  - Each cycle row_i==0 increments the release counter; any nonzero row_i clears it.
  - Counter reaches RELEASE_CYC: advance column, reload settle counter, go to SETTLE.
  - A second key pressed in the same column while HELD produces no event.
- Event emission:
  - Registered: key_valid rises on the edge after the SAMPLE cycle (latency 1 from sample).
  - key_code and key_valid stay stable while key_valid && !key_ready.
  - Handshake completes on an edge with key_valid && key_ready; key_valid drops the next cycle unless a new event loads in the same edge.
  - Same-edge accept + new event: new code loads, key_valid stays 1, no overflow.
  - Event while key_valid && !key_ready: event dropped, ovf set, held code unchanged.
- ovf:
  - Cleared only by ovf_clr.
  - ovf_clr coincident with a new overflow: set wins.
- Counter width: $clog2(max(SETTLE_CYC,RELEASE_CYC)+1). Settle and release use one shared counter.
- Scan period with no keys: N_COLS*(SETTLE_CYC+1) cycles (36 at defaults).
- Reset mid-operation:
  - Pending key is discarded and ovf is cleared.
  - Scanning restarts at column 0.
- Invariant: col_o is always exactly one-hot, never 0.

Decomposition:
- keypad_pkg:
  - state enum {SETTLE, SAMPLE, HELD}.
  - KEY_W localparam function.
  - Named key-code constants for the calculator keys (digits 0-9, operators, '=' and clear).
- Sub-module keypad_key_slot: one-entry output register with valid/ready, load/drop logic and sticky ovf. Scanner FSM, column shifter and counter stay in keypad_scanner.

Test Plan:
- Reset, then no keys for 72 cycles -> col_o cycles 0001,0010,0100,1000,0001,... each held 9 cycles; key_valid stays 0.
- Row_i=0100 while col_o=0010, key_ready=1 -> key_code=9 (row2*4+col1) with a one-cycle key_valid pulse one cycle after SAMPLE; col_o holds 0010 until row_i is 0 for 4 cycles, then moves to 0100.
- key_ready=0, two presses in sequence (code 0, then code 15) -> key_code stays 0, key_valid stays 1, ovf=1. Pulse ovf_clr -> ovf=0, key_code still 0.
- key_ready asserted on the exact edge a new event (code 5) loads while code 3 is pending -> 3 consumed, 5 loaded, key_valid stays 1, ovf stays 0.
- Row_i=0011 at SAMPLE -> no event; state HELD until release, then scanning resumes.
- rst_n pulsed low mid-HELD with key_valid=1 -> outputs immediately return to reset values (col_o=0001, key_valid=0, ovf=0); scan restarts at column 0.
